mux_arb_nch: RTL and testbench
==============================

// Module: mux_arb_nch
// PURPOSE
//  Parametrised N-channel, WIDTH-bit registered selector; successor to the 4-bit 2:1 select mux.
//  Arbitrates among valid/ready input channels and forwards one word per cycle to a registered output.
//  A direct-select override (force_en/force_ch) reproduces the legacy s-driven mux selection.
//  Sits between carry-select adder result stages and a shared downstream consumer.
// PARAMETERS
//  WIDTH  4  data width per channel, >=1
//  NCH    4  number of input channels, >=2
//  SELW   $clog2(NCH)  localparam: channel-index width
// PORTS
//  clk        in   1          clock, all state on rising edge
//  rst_n      in   1          asynchronous active-low reset
//  in_data    in   NCH*WIDTH  channel i at [i*WIDTH +: WIDTH]
//  in_valid   in   NCH        per-channel valid
//  in_ready   out  NCH        per-channel ready, at most one bit high (one-hot or zero)
//  force_en   in   1          1: only force_ch may be granted
//  force_ch   in   SELW       forced channel index
//  out_data   out  WIDTH      registered selected word
//  out_ch     out  SELW       index of channel that produced out_data
//  out_valid  out  1          output register holds a word
//  out_ready  in   1          downstream accepts
// BEHAVIOUR
//  Reset (async, rst_n=0): out_valid=0, out_data=0, out_ch=0, rr pointer=0; in_ready=0 while in reset.
//  load = ~out_valid | out_ready (one-entry output buffer; no skid).
//  grant: one-hot over in_valid (subject to force), combinational; in_ready = grant & {NCH{load}}.
//  Transfer on channel g when in_valid[g] & in_ready[g]: next edge out_data<=in_data[g], out_ch<=g, out_valid<=1.
//  Latency: 1 cycle input->output; throughput 1 word/cycle when out_ready held 1.
//  load=1 and no grant: out_valid<=0 (out_data/out_ch hold last value).
//  out_valid=1 & out_ready=0: out_data, out_ch, out_valid held stable; all in_ready=0.
//  Simultaneous output drain and new grant in same cycle: both occur, no bubble.
//  force_en=1: grant = force_ch only if in_valid[force_ch]; force_ch>=NCH -> no grant.
//  rr pointer: on every transfer, ptr <= (g==NCH-1) ? 0 : g+1 (wrap-around), forced or not.
//  rst_n asserted mid-transfer: in-flight word dropped, outputs return to reset values immediately.
//  No combinational path from in_valid to out_valid; out_ready->in_ready is combinational.
// CONFIGURATION
//  MUX_ARB_RR_EN defined: round-robin; search starts at ptr, lowest index at/after ptr wins, wraps to 0.
//  MUX_ARB_RR_EN undefined: fixed priority, lowest valid index wins; ptr still maintained but unused.
//  force_en override behaves identically in both builds.
// STRUCTURE
//  Package mux_arb_pkg: WIDTH/NCH defaults, clog2-based SELW function, ptr-advance helper function.
//  Sub-module arb_pick (NCH): req, ptr -> one-hot grant + encoded index; RR vs fixed selected by macro.
//  Top holds output register, ptr register, force masking and ready generation.
// TESTING
//  Reset: rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0.
//  Legacy mux: NCH=2,WIDTH=4, ch0=4'b1010, ch1=4'b0101, force_en=1, force_ch=0 then 1
//    -> out_data 4'b1010 (out_ch 0) then 4'b0101 (out_ch 1), one cycle after each grant.
//  RR (MUX_ARB_RR_EN): NCH=4 all valid, out_ready=1 -> out_ch 0,1,2,3,0 on consecutive cycles;
//    fixed-priority build -> out_ch 0 every cycle.
//  Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_ch stable, in_ready=0;
//    out_ready=1 -> next word loaded same edge, no bubble.
//  Force edge: force_en=1, force_ch=2, in_valid=4'b1011 -> no grant, out_valid falls to 0;
//    force_ch=3 -> out_ch=3, ptr wraps to 0.
//  Async reset mid-stream: drop rst_n between edges while out_valid=1 -> out_valid=0 without clock edge.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared defaults and helpers for the mux_arb_nch registered N-channel selector.
package mux_arb_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int NCH_DEF   = 4;

  // Channel-index width; at least one bit so a two-channel build still has a select line.
  function automatic int sel_w(input int nch);
    return (nch < 2) ? 1 : $clog2(nch);
  endfunction

  function automatic int ptr_next(input int g, input int nch);
    return (g == nch - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/mux_arb_nch_arb_pick.sv
// One-hot picker over a request vector; round-robin from ptr when MUX_ARB_RR_EN is
// defined, otherwise fixed priority with the lowest index winning.
module arb_pick #(
  parameter int NCH  = 4,
  parameter int SELW = 2
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  gnt,
  output logic [SELW-1:0] gnt_idx
);

  logic found;

`ifndef MUX_ARB_RR_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  always_comb begin
    int idx;
    // NOTE: every output of this block gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NCH; k++) begin
`ifdef MUX_ARB_RR_EN
      idx = (int'(ptr) + k) % NCH;
`else
      idx = k;
`endif
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = SELW'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_arb_nch.sv
// N-channel WIDTH-bit registered selector with valid/ready arbitration and a
// force_en/force_ch direct-select override. Round-robin build: define MUX_ARB_RR_EN.
module mux_arb_nch
  import mux_arb_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int NCH   = NCH_DEF,
  localparam int SELW  = sel_w(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 force_en,
  input  logic [SELW-1:0]      force_ch,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic [NCH-1:0]   req;
  logic [NCH-1:0]   gnt;
  logic [SELW-1:0]  gnt_idx;
  logic             load;
  logic             xfer;

  // Force narrows the request set to a single in-range channel; an out-of-range index grants nothing.
  always_comb begin
    req = in_valid;
    if (force_en) begin
      req = '0;
      if (int'(force_ch) < NCH) req[force_ch] = in_valid[force_ch];
    end
  end

  arb_pick #(.NCH(NCH), .SELW(SELW)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // One-entry output buffer: accept only when empty or draining this cycle; nothing accepted in reset.
  assign load     = ~out_valid_q | out_ready;
  assign in_ready = gnt & {NCH{load & rst_n}};
  assign xfer     = |in_ready;

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
      out_ch_d    = gnt_idx;
      out_valid_d = 1'b1;
      ptr_d       = SELW'(ptr_next(int'(gnt_idx), NCH));
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_nch.sv
// Directed bench for mux_arb_nch: a 4-channel instance for arbitration/backpressure/force
// and a 2-channel instance for the legacy select-mux behaviour.
module tb_mux_arb_nch;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [15:0] in_data4;
  logic [3:0]  in_valid4, in_ready4;
  logic        force_en4;
  logic [1:0]  force_ch4;
  logic [3:0]  out_data4;
  logic [1:0]  out_ch4;
  logic        out_valid4, out_ready4;

  logic [7:0]  in_data2;
  logic [1:0]  in_valid2, in_ready2;
  logic        force_en2;
  logic [0:0]  force_ch2;
  logic [3:0]  out_data2;
  logic [0:0]  out_ch2;
  logic        out_valid2, out_ready2;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_ptr = 0;

  mux_arb_nch #(.WIDTH(4), .NCH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
    .force_en(force_en4), .force_ch(force_ch4), .out_data(out_data4), .out_ch(out_ch4),
    .out_valid(out_valid4), .out_ready(out_ready4)
  );

  mux_arb_nch #(.WIDTH(4), .NCH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .force_en(force_en2), .force_ch(force_ch2), .out_data(out_data2), .out_ch(out_ch2),
    .out_valid(out_valid2), .out_ready(out_ready2)
  );

  // Reference pick for the 4-channel instance, unforced.
  function automatic int exp_pick(input logic [3:0] v, input int p);
`ifdef MUX_ARB_RR_EN
    for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
`else
    for (int k = 0; k < 4; k++) if (v[k]) return k;
`endif
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_data4 = 16'hDCBA; in_valid4 = 4'b1111; force_en4 = 1'b0; force_ch4 = 2'd0; out_ready4 = 1'b1;
    in_data2 = 8'h5A;    in_valid2 = 2'b11;   force_en2 = 1'b0; force_ch2 = 1'b0; out_ready2 = 1'b1;
    repeat (3) step();
    n_cmp++; if (out_valid4 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid4); end
    n_cmp++; if (out_data4 !== 4'h0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", out_data4); end
    n_cmp++; if (out_ch4 !== 2'd0) begin n_bad++; $display("FAIL reset_out_ch: got %0d want 0", out_ch4); end
    n_cmp++; if (in_ready4 !== 4'b0000) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0000", in_ready4); end
    n_cmp++; if (in_ready2 !== 2'b00) begin n_bad++; $display("FAIL reset_in_ready2: got %b want 00", in_ready2); end
    in_valid4 = 4'b0000; in_valid2 = 2'b00;
    rst_n = 1'b1;
    step();
    exp_ptr = 0;
  endtask

  task automatic test_legacy_mux();
    in_data2 = {4'b0101, 4'b1010}; in_valid2 = 2'b11; force_en2 = 1'b1; force_ch2 = 1'b0; out_ready2 = 1'b1;
    #1;
    n_cmp++; if (in_ready2 !== 2'b01) begin n_bad++; $display("FAIL legacy_ready0: got %b want 01", in_ready2); end
    step();
    n_cmp++; if (out_data2 !== 4'b1010) begin n_bad++; $display("FAIL legacy_data0: got %b want 1010", out_data2); end
    n_cmp++; if (out_ch2 !== 1'b0) begin n_bad++; $display("FAIL legacy_ch0: got %0d want 0", out_ch2); end
    force_ch2 = 1'b1;
    #1;
    n_cmp++; if (out_data2 !== 4'b1010) begin n_bad++; $display("FAIL legacy_hold: got %b want 1010", out_data2); end
    step();
    n_cmp++; if (out_data2 !== 4'b0101) begin n_bad++; $display("FAIL legacy_data1: got %b want 0101", out_data2); end
    n_cmp++; if (out_ch2 !== 1'b1) begin n_bad++; $display("FAIL legacy_ch1: got %0d want 1", out_ch2); end
    n_cmp++; if (out_valid2 !== 1'b1) begin n_bad++; $display("FAIL legacy_valid: got %b want 1", out_valid2); end
    in_valid2 = 2'b00;
    step();
    n_cmp++; if (out_valid2 !== 1'b0) begin n_bad++; $display("FAIL legacy_drain: got %b want 0", out_valid2); end
  endtask

  task automatic test_arbitration();
    int seq [5];
`ifdef MUX_ARB_RR_EN
    seq = '{0, 1, 2, 3, 0};
`else
    seq = '{0, 0, 0, 0, 0};
`endif
    force_en4 = 1'b0; in_data4 = 16'hDCBA; in_valid4 = 4'b1111; out_ready4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (out_ch4 !== 2'(seq[i]) || out_data4 !== 4'(4'hA + seq[i]) || out_valid4 !== 1'b1) begin
        n_bad++;
        $display("FAIL arb_cycle%0d: got ch=%0d data=%h v=%b want ch=%0d data=%h v=1",
                 i, out_ch4, out_data4, out_valid4, seq[i], 4'(4'hA + seq[i]));
      end
    end
    exp_ptr = 1;
    in_valid4 = 4'b0000;
    step();
    n_cmp++; if (out_valid4 !== 1'b0 || out_ch4 !== 2'd0 || out_data4 !== 4'hA) begin
      n_bad++; $display("FAIL arb_idle: got v=%b ch=%0d data=%h want v=0 ch=0 data=a", out_valid4, out_ch4, out_data4);
    end
  endtask

  task automatic test_back_to_back();
    int e1, e2;
    in_valid4 = 4'b1111; out_ready4 = 1'b1;
    e1 = exp_pick(4'b1111, exp_ptr);
    exp_ptr = (e1 == 3) ? 0 : e1 + 1;
    step();
    out_ready4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (in_ready4 !== 4'b0000) begin n_bad++; $display("FAIL bp_ready%0d: got %b want 0000", i, in_ready4); end
      step();
      n_cmp++; if (out_valid4 !== 1'b1 || out_ch4 !== 2'(e1) || out_data4 !== 4'(4'hA + e1)) begin
        n_bad++; $display("FAIL bp_hold%0d: got v=%b ch=%0d data=%h want v=1 ch=%0d", i, out_valid4, out_ch4, out_data4, e1);
      end
    end
    out_ready4 = 1'b1;
    e2 = exp_pick(4'b1111, exp_ptr);
    exp_ptr = (e2 == 3) ? 0 : e2 + 1;
    #1;
    n_cmp++; if (in_ready4 !== 4'(1 << e2)) begin n_bad++; $display("FAIL bp_release_ready: got %b want %b", in_ready4, 4'(1 << e2)); end
    step();
    n_cmp++; if (out_valid4 !== 1'b1 || out_ch4 !== 2'(e2) || out_data4 !== 4'(4'hA + e2)) begin
      n_bad++; $display("FAIL bp_no_bubble: got v=%b ch=%0d data=%h want v=1 ch=%0d", out_valid4, out_ch4, out_data4, e2);
    end
  endtask

  task automatic test_force_edge();
    force_en4 = 1'b1; force_ch4 = 2'd2; in_valid4 = 4'b1011; out_ready4 = 1'b1;
    #1;
    n_cmp++; if (in_ready4 !== 4'b0000) begin n_bad++; $display("FAIL force_nogrant_ready: got %b want 0000", in_ready4); end
    step();
    n_cmp++; if (out_valid4 !== 1'b0) begin n_bad++; $display("FAIL force_nogrant_valid: got %b want 0", out_valid4); end
    force_ch4 = 2'd3;
    #1;
    n_cmp++; if (in_ready4 !== 4'b1000) begin n_bad++; $display("FAIL force3_ready: got %b want 1000", in_ready4); end
    step();
    n_cmp++; if (out_valid4 !== 1'b1 || out_ch4 !== 2'd3 || out_data4 !== 4'hD) begin
      n_bad++; $display("FAIL force3_out: got v=%b ch=%0d data=%h want v=1 ch=3 data=d", out_valid4, out_ch4, out_data4);
    end
    // Pointer wrapped to 0, so the next unforced pick is channel 0 in either build.
    force_en4 = 1'b0; in_valid4 = 4'b1111;
    step();
    n_cmp++; if (out_ch4 !== 2'd0 || out_data4 !== 4'hA) begin
      n_bad++; $display("FAIL force_wrap: got ch=%0d data=%h want ch=0 data=a", out_ch4, out_data4);
    end
  endtask

  task automatic test_async_reset();
    in_valid4 = 4'b1111; out_ready4 = 1'b1;
    step();
    n_cmp++; if (out_valid4 !== 1'b1) begin n_bad++; $display("FAIL areset_pre: got %b want 1", out_valid4); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid4 !== 1'b0 || out_data4 !== 4'h0 || out_ch4 !== 2'd0) begin
      n_bad++; $display("FAIL areset_now: got v=%b ch=%0d data=%h want all 0", out_valid4, out_ch4, out_data4);
    end
    n_cmp++; if (in_ready4 !== 4'b0000) begin n_bad++; $display("FAIL areset_ready: got %b want 0000", in_ready4); end
    step();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready4 !== 4'b0001) begin n_bad++; $display("FAIL areset_ptr: got %b want 0001", in_ready4); end
  endtask

  initial begin
    test_reset();
    test_legacy_mux();
    test_arbitration();
    test_back_to_back();
    test_force_edge();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
